// File: rtl/sol1_bus_responder_pkg.sv
// Shared types for the sol1 bus responder: FSM state encoding and wait counter width.
package pa_bus_resp;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } e_resp_state;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/sol1_resp_bank.sv
// 2^ADDR_W x 8 register bank: synchronous write, registered read, synchronous clear.
module sol1_resp_bank #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Storage and read register; clear has priority over any access.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      rdata_q <= 8'h00;
    end else begin
      if (we) begin
        mem_q[waddr] <= wdata;
      end
      if (re) begin
        rdata_q <= mem_q[raddr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sol1_bus_responder.sv
// Target-side endpoint of the CPU external bus with programmable wait states.
// Define SOL1_RESP_DOORBELL_EN to make writes to DOORBELL_OFS pulse irq.
module sol1_bus_responder
  import pa_bus_resp::*;
#(
  parameter logic [21:0] BASE_ADDR    = 22'h3F_FF00,
  parameter int          ADDR_W       = 4,
  parameter int          WAIT_STATES  = 2,
  parameter logic        MEM_IO_SEL   = 1'b1,
  parameter int          DOORBELL_OFS = (1 << ADDR_W) - 1
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [21:0] addr,
  input  logic        mem_io,
  input  logic        rd,
  input  logic        wr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        wait_out,
  output logic        irq
);

  if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait
    $error("sol1_bus_responder: WAIT_STATES must be 1..15");
  end
  if (ADDR_W < 1 || ADDR_W > 8) begin : g_bad_addr_w
    $error("sol1_bus_responder: ADDR_W must be 1..8");
  end
  if (BASE_ADDR[ADDR_W-1:0] != '0) begin : g_bad_base
    $error("sol1_bus_responder: BASE_ADDR low bits must be zero");
  end
  if (DOORBELL_OFS >= (1 << ADDR_W)) begin : g_bad_db
    $error("sol1_bus_responder: DOORBELL_OFS outside window");
  end

  localparam logic [WAIT_CNT_W-1:0] CNT_INIT = WAIT_CNT_W'(WAIT_STATES - 2);
`ifdef SOL1_RESP_DOORBELL_EN
  localparam logic [ADDR_W-1:0] DB_OFS = DOORBELL_OFS[ADDR_W-1:0];
`endif

  e_resp_state           state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]     ofs_q, ofs_d;
  logic                  dir_q, dir_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  data_oe_q, data_oe_d;
  logic                  irq_q, irq_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic                  sel_s, hit_s, wait_s, enter_ack_s;
  logic                  commit_s, read_s;
  logic [ADDR_W-1:0]     acc_ofs_s;
  logic [7:0]            acc_data_s;
  logic                  acc_dir_s;
  logic [7:0]            bank_rdata_s;

  assign sel_s = (mem_io == MEM_IO_SEL) && (addr[21:ADDR_W] == BASE_ADDR[21:ADDR_W]);
  assign hit_s = sel_s && (rd ^ wr);

  // Next-state, access latch and error counting; a single-wait-state access goes straight to ACK.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ofs_d       = ofs_q;
    dir_d       = dir_q;
    wdata_d     = wdata_q;
    data_oe_d   = data_oe_q;
    err_cnt_d   = err_cnt_q;
    wait_s      = 1'b0;
    enter_ack_s = 1'b0;
    acc_ofs_s   = ofs_q;
    acc_data_s  = wdata_q;
    acc_dir_s   = dir_q;
    case (state_q)
      ST_IDLE: begin
        wait_s     = hit_s;
        acc_ofs_s  = addr[ADDR_W-1:0];
        acc_data_s = data_in;
        acc_dir_s  = wr;
        if (hit_s) begin
          ofs_d   = addr[ADDR_W-1:0];
          dir_d   = wr;
          wdata_d = data_in;
          if (WAIT_STATES == 1) begin
            enter_ack_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else if (sel_s && rd && wr && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end else begin
          err_cnt_d = err_cnt_q;
        end
      end
      ST_WAIT: begin
        wait_s = 1'b1;
        if (dir_q ? !wr : !rd) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end else begin
          enter_ack_s = 1'b1;
        end
      end
      ST_ACK: begin
        if (!rd && !wr) begin
          state_d   = ST_IDLE;
          data_oe_d = 1'b0;
        end else begin
          state_d = ST_ACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_ack_s) begin
      state_d = ST_ACK;
      if (!acc_dir_s) begin
        data_oe_d = 1'b1;
      end else begin
        data_oe_d = data_oe_q;
      end
    end else begin
      data_oe_d = data_oe_d;
    end
  end

  assign commit_s = enter_ack_s && acc_dir_s;
  assign read_s   = enter_ack_s && !acc_dir_s;

  // Doorbell pulse is a single cycle on the edge that enters ACK.
  always_comb begin
`ifdef SOL1_RESP_DOORBELL_EN
    irq_d = commit_s && (acc_ofs_s == DB_OFS);
`else
    irq_d = 1'b0;
`endif
  end

  // State and access registers.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ofs_q     <= '0;
      dir_q     <= 1'b0;
      wdata_q   <= 8'h00;
      data_oe_q <= 1'b0;
      irq_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ofs_q     <= ofs_d;
      dir_q     <= dir_d;
      wdata_q   <= wdata_d;
      data_oe_q <= data_oe_d;
      irq_q     <= irq_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  sol1_resp_bank #(
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk  (clk),
    .clr  (arst),
    .we   (commit_s),
    .waddr(acc_ofs_s),
    .wdata(acc_data_s),
    .re   (read_s),
    .raddr(acc_ofs_s),
    .rdata(bank_rdata_s)
  );

  // Reset forces wait_out low even if a strobe is still held through it.
  assign wait_out = wait_s && !arst;
  assign data_oe  = data_oe_q;
  assign data_out = data_oe_q ? bank_rdata_s : 8'h00;
  assign irq      = irq_q;

endmodule

// File: tb/tb_sol1_bus_responder.sv
// Directed table-driven bench for sol1_bus_responder (default parameters, WAIT_STATES=2).
module tb_sol1_bus_responder;
  import pa_bus_resp::*;

  localparam logic [21:0] B = 22'h3F_FF00;
`ifdef SOL1_RESP_DOORBELL_EN
  localparam logic DB = 1'b1;
`else
  localparam logic DB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [21:0] addr = 22'h0;
  logic        mem_io = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        wait_out;
  logic        irq;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sol1_bus_responder dut (
    .clk(clk), .arst(arst), .addr(addr), .mem_io(mem_io), .rd(rd), .wr(wr),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .wait_out(wait_out), .irq(irq)
  );

  typedef struct {
    logic        rst;
    logic        mio;
    logic        r;
    logic        w;
    logic [21:0] a;
    logic [7:0]  din;
    logic        ew;
    logic        eoe;
    logic [7:0]  edo;
    logic        eirq;
    string       nm;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic mio, input logic r, input logic w,
                     input int ofs, input logic [7:0] din, input logic ew, input logic eoe,
                     input logic [7:0] edo, input logic eirq, input string nm);
    vec_t v;
    v.rst = rst; v.mio = mio; v.r = r; v.w = w; v.a = B + 22'(ofs); v.din = din;
    v.ew = ew; v.eoe = eoe; v.edo = edo; v.eirq = eirq; v.nm = nm;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      arst = vq[i].rst; mem_io = vq[i].mio; rd = vq[i].r; wr = vq[i].w;
      addr = vq[i].a; data_in = vq[i].din;
      #1;
      chk($sformatf("%s[%0d].wait", vq[i].nm, i), {7'd0, wait_out}, {7'd0, vq[i].ew});
      chk($sformatf("%s[%0d].oe", vq[i].nm, i), {7'd0, data_oe}, {7'd0, vq[i].eoe});
      chk($sformatf("%s[%0d].dout", vq[i].nm, i), data_out, vq[i].edo);
      chk($sformatf("%s[%0d].irq", vq[i].nm, i), {7'd0, irq}, {7'd0, vq[i].eirq});
    end
  endtask

  int seg_err, seg_rst;

  initial begin
    //  rst mio rd wr ofs din    wait oe dout  irq
    add(1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "reset");
    add(1'b0, 1'b1, 1'b1, 1'b0, 3, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "rd3");
    add(1'b0, 1'b1, 1'b1, 1'b0, 3, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "rd3");
    add(1'b0, 1'b1, 1'b1, 1'b0, 3, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, "rd3");
    add(1'b0, 1'b1, 1'b0, 1'b0, 3, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, "rd3");
    add(1'b0, 1'b1, 1'b0, 1'b0, 3, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "idle");
    add(1'b0, 1'b1, 1'b0, 1'b1, 5, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, "wr5");
    add(1'b0, 1'b1, 1'b0, 1'b1, 6, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, "wr5");
    add(1'b0, 1'b1, 1'b0, 1'b1, 6, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, "wr5");
    add(1'b0, 1'b1, 1'b0, 1'b0, 6, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, "wr5");
    add(1'b0, 1'b1, 1'b1, 1'b0, 5, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "rd5");
    add(1'b0, 1'b1, 1'b1, 1'b0, 5, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "rd5");
    add(1'b0, 1'b1, 1'b1, 1'b0, 5, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, "rd5");
    add(1'b0, 1'b1, 1'b0, 1'b0, 5, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, "rd5");
    add(1'b0, 1'b1, 1'b0, 1'b0, 5, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "idle");
    add(1'b0, 1'b1, 1'b1, 1'b0, 16, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "outside");
    add(1'b0, 1'b1, 1'b1, 1'b0, 16, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "outside");
    add(1'b0, 1'b0, 1'b1, 1'b0, 3, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "memsp");
    add(1'b0, 1'b1, 1'b0, 1'b0, 3, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "idle");
    add(1'b0, 1'b1, 1'b0, 1'b1, 2, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b0, "abort");
    add(1'b0, 1'b1, 1'b0, 1'b0, 2, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b0, "abort");
    add(1'b0, 1'b1, 1'b0, 1'b0, 2, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "abort");
    add(1'b0, 1'b1, 1'b1, 1'b0, 2, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "rd2");
    add(1'b0, 1'b1, 1'b1, 1'b0, 2, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "rd2");
    add(1'b0, 1'b1, 1'b1, 1'b0, 2, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, "rd2");
    add(1'b0, 1'b1, 1'b0, 1'b0, 2, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, "rd2");
    add(1'b0, 1'b1, 1'b0, 1'b0, 2, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "idle");
    add(1'b0, 1'b1, 1'b1, 1'b1, 1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, "rdwr");
    add(1'b0, 1'b1, 1'b1, 1'b1, 1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, "rdwr");
    add(1'b0, 1'b1, 1'b1, 1'b1, 1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, "rdwr");
    add(1'b0, 1'b1, 1'b0, 1'b0, 1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "idle");
    seg_err = vq.size();
    add(1'b0, 1'b1, 1'b0, 1'b1, 15, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, "db");
    add(1'b0, 1'b1, 1'b0, 1'b1, 15, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, "db");
    add(1'b0, 1'b1, 1'b0, 1'b0, 15, 8'h00, 1'b0, 1'b0, 8'h00, DB, "db");
    add(1'b0, 1'b1, 1'b0, 1'b0, 15, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "db");
    add(1'b0, 1'b1, 1'b1, 1'b0, 15, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "rd15");
    add(1'b0, 1'b1, 1'b1, 1'b0, 15, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "rd15");
    add(1'b0, 1'b1, 1'b0, 1'b0, 15, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, "rd15");
    add(1'b0, 1'b1, 1'b0, 1'b0, 15, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "idle");
    add(1'b0, 1'b1, 1'b1, 1'b0, 3, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "rstmid");
    add(1'b1, 1'b1, 1'b1, 1'b0, 3, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "rstmid");
    add(1'b0, 1'b1, 1'b0, 1'b0, 3, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "rstmid");
    seg_rst = vq.size();
    add(1'b0, 1'b1, 1'b1, 1'b0, 5, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "rd5clr");
    add(1'b0, 1'b1, 1'b1, 1'b0, 5, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "rd5clr");
    add(1'b0, 1'b1, 1'b0, 1'b0, 5, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, "rd5clr");
    add(1'b0, 1'b1, 1'b0, 1'b0, 5, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "idle");

    run(0, seg_err);
    chk("err_cnt_after_rdwr", dut.err_cnt_q, 8'd3);

    run(seg_err, seg_rst);
    chk("state_after_rst", 8'(dut.state_q), 8'(ST_IDLE));
    chk("err_cnt_after_rst", dut.err_cnt_q, 8'd0);

    run(seg_rst, vq.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
